// File: rtl/vm_lcd_pkg.sv
// Shared constants, state encoding and text helpers for the vending machine LCD text composer.
package vm_lcd_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_BUILD} state_t;

  localparam logic [7:0]  CH_SP   = 8'h20;
  localparam logic [7:0]  CH_0    = 8'h30;
  localparam logic [7:0]  CH_DASH = 8'h2D;
  localparam logic [7:0]  CH_W    = 8'h57;

  localparam logic [39:0] STR_CASH  = "CASH:";
  localparam logic [31:0] STR_ITEM  = "ITEM";
  localparam logic [39:0] STR_STOCK = "STOCK";
  localparam logic [79:0] STR_ADMIN = "ADMIN MODE";
  localparam logic [15:0] STR_SO    = "SO";

  localparam logic [6:0]  ADDR_CUST  = 7'h46;
  localparam logic [6:0]  ADDR_ADMIN = 7'h4F;

  localparam logic [13:0] MAX_SHOWN = 14'd9999;
  localparam logic [3:0]  NUM_ITEMS = 4'd12;

  typedef struct packed {
    logic        admin;
    logic [13:0] money;
    logic [3:0]  item;
    logic [13:0] price;
    logic [3:0]  stock;
  } snap_t;

  function automatic logic [13:0] saturate(input logic [13:0] v);
    return (v > MAX_SHOWN) ? MAX_SHOWN : v;
  endfunction

  // Right-aligned 4-digit field; leading zeros blank, the units digit never does.
  function automatic logic [31:0] fmt4(input logic [15:0] bcd);
    logic [31:0] s;
    s = {CH_0 + {4'h0, bcd[15:12]}, CH_0 + {4'h0, bcd[11:8]},
         CH_0 + {4'h0, bcd[7:4]},   CH_0 + {4'h0, bcd[3:0]}};
    if (bcd[15:12] == 4'd0) s[31:24] = CH_SP;
    if (bcd[15:8]  == 8'd0) s[23:16] = CH_SP;
    if (bcd[15:4]  == 12'd0) s[15:8] = CH_SP;
    return s;
  endfunction

  function automatic logic [15:0] fmt2(input logic [4:0] v);
    logic       tens;
    logic [4:0] ones;
    tens = (v >= 5'd10);
    ones = tens ? v - 5'd10 : v;
    return {CH_0 + {7'd0, tens}, CH_0 + {4'h0, ones[3:0]}};
  endfunction

endpackage

// File: rtl/vm_lcd_text_composer_bin2bcd.sv
// Iterative 14-bit double-dabble; the load edge also performs the first shift.
module bin2bcd_seq (
  input  logic        clk_100hz,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [29:0] sr;
  logic [3:0]  cnt;
  logic        run;

  function automatic logic [29:0] step(input logic [29:0] v);
    logic [29:0] t;
    t = v;
    for (int i = 0; i < 4; i++)
      if (t[14 + 4*i +: 4] >= 4'd5) t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
    return {t[28:0], 1'b0};
  endfunction

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      sr   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      // Add-3 on an all-zero BCD field is a no-op, so iteration 1 is a plain shift.
      sr   <= {15'd0, bin, 1'b0};
      cnt  <= 4'd13;
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      if (cnt != 4'd0) begin
        sr  <= step(sr);
        cnt <= cnt - 4'd1;
      end else begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign bcd = sr[29:14];

endmodule

// File: rtl/vm_lcd_text_composer.sv
// Formats the two LCD text lines and cursor address from a snapshot of the machine state.
module vm_lcd_text_composer
  import vm_lcd_pkg::*;
(
  input  logic         clk_100hz,
  input  logic         rst,
  input  logic         admin_mode,
  input  logic [13:0]  money,
  input  logic [3:0]   item_sel,
  input  logic [13:0]  item_price,
  input  logic [3:0]   item_stock,
  output logic [127:0] line1_text,
  output logic [127:0] line2_text,
  output logic [6:0]   ddram_address,
  output logic         busy
);

  state_t      state, state_nx;
  snap_t       snap, live;
  logic        snap_valid, mismatch, start;
  logic [15:0] money_bcd, price_bcd;
  logic        money_done, price_done;

  assign live     = {admin_mode, money, item_sel, item_price, item_stock};
  assign mismatch = !snap_valid || (live != snap);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      S_IDLE:  if (mismatch) state_nx = S_LOAD;
      S_LOAD:  begin start = 1'b1; state_nx = S_CONV; end
      S_CONV:  if (money_done && price_done) state_nx = S_BUILD;
      S_BUILD: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      snap       <= '0;
      snap_valid <= 1'b0;
    end else if (state == S_IDLE && mismatch) begin
      snap       <= live;
      snap_valid <= 1'b1;
    end
  end

  bin2bcd_seq u_money_bcd (
    .clk_100hz (clk_100hz),
    .rst       (rst),
    .start     (start),
    .bin       (saturate(snap.money)),
    .bcd       (money_bcd),
    .done      (money_done)
  );

  bin2bcd_seq u_price_bcd (
    .clk_100hz (clk_100hz),
    .rst       (rst),
    .start     (start),
    .bin       (saturate(snap.price)),
    .bcd       (price_bcd),
    .done      (price_done)
  );

  logic         valid;
  logic [15:0]  item2, stock2, stock_cust;
  logic [127:0] l1_nx, l2_nx;
  logic [6:0]   addr_nx;

  assign valid      = (snap.item < NUM_ITEMS);
  assign item2      = valid ? fmt2({1'b0, snap.item} + 5'd1) : {2{CH_DASH}};
  assign stock2     = valid ? fmt2({1'b0, snap.stock}) : {2{CH_DASH}};
  assign stock_cust = (valid && snap.stock == 4'd0) ? STR_SO : stock2;

  always_comb begin
    l1_nx   = {16{CH_SP}};
    l2_nx   = {16{CH_SP}};
    addr_nx = ADDR_CUST;
    if (snap.admin) begin
      l1_nx   = {STR_ADMIN, {6{CH_SP}}};
      l2_nx   = {STR_ITEM, CH_SP, item2, CH_SP, STR_STOCK, CH_SP, stock2};
      addr_nx = ADDR_ADMIN;
    end else begin
      l1_nx = {STR_CASH, {6{CH_SP}}, fmt4(money_bcd), CH_W};
      l2_nx = {STR_ITEM, CH_SP, item2, CH_SP,
               valid ? fmt4(price_bcd) : {4{CH_DASH}}, CH_W, CH_SP, stock_cust};
    end
  end

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      line1_text    <= {16{CH_SP}};
      line2_text    <= {16{CH_SP}};
      ddram_address <= 7'h00;
    end else if (state == S_BUILD) begin
      line1_text    <= l1_nx;
      line2_text    <= l2_nx;
      ddram_address <= addr_nx;
    end
  end

endmodule
